uart_tx_fifo_io: RTL and testbench



---
 rtl/uart_tx_fifo_io.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_fifo_io.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_io.sv
// uart_tx_fifo_io: Z80 I/O-mapped 8N1 UART transmitter with TX FIFO, status port and sticky overflow.
// Define UART_TX_FIFO_IO_IRQ_EN to add the control port and the registered TX-idle interrupt.
module uart_tx_fifo_io #(
  parameter int         CLK_HZ      = 50000000,
  parameter int         BAUD        = 115200,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] DATA_PORT   = 8'h00,
  parameter logic [7:0] STATUS_PORT = 8'h02,
  parameter logic [7:0] CTRL_PORT   = 8'h03
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Address,
  inout  wire  [7:0] Data,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  output logic       uart_tx,
  output logic       irq
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  // Strobe synchroniser; the push fires two edges after the strobe is first seen
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= IORQ & WR & ~RD;
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic wrPulse, dataWr, statusWr;
  assign wrPulse  = s2 & ~s3;
  assign dataWr   = wrPulse && (Address == DATA_PORT);
  assign statusWr = wrPulse && (Address == STATUS_PORT);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wPtr, rPtr;
  logic [CW-1:0] count;
  logic          fifoFull, fifoEmpty, push, pop;
  txState_t      state;
  logic [BW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          baudEnd, overflow, txIdle;

  assign fifoFull  = (count == CW'(FIFO_DEPTH));
  assign fifoEmpty = (count == '0);
  assign baudEnd   = (baudCnt == BW'(DIV - 1));
  assign pop       = !fifoEmpty && (state == IDLE || (state == STOP && baudEnd));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign push      = dataWr && (!fifoFull || pop);
  assign txIdle    = fifoEmpty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wPtr] <= Data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wPtr  <= '0;
      rPtr  <= '0;
      count <= '0;
    end else begin
      if (push) wPtr <= wPtr + 1'b1;
      if (pop)  rPtr <= rPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                overflow <= 1'b0;
    else if (dataWr && !push) overflow <= 1'b1;
    else if (statusWr)        overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          baudCnt <= '0;
          if (pop) begin
            shiftReg <= mem[rPtr];
            state    <= START;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (baudEnd) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            state   <= DATA;
            uart_tx <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 1'b1;
              shiftReg <= shiftReg >> 1;
              uart_tx  <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudEnd) begin
            baudCnt <= '0;
            // Queued data starts the next frame with no idle gap
            if (pop) begin
              shiftReg <= mem[rPtr];
              state    <= START;
              uart_tx  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [4:0] cntSat;
  logic [7:0] statusByte;
  assign cntSat     = (int'(count) > 31) ? 5'd31 : 5'(count);
  assign statusByte = {cntSat, overflow, txIdle, fifoFull};
  assign Data       = (IORQ && RD && !WR && Address == STATUS_PORT) ? statusByte : 8'bz;

`ifdef UART_TX_FIFO_IO_IRQ_EN
  logic irqEnable;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqEnable <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wrPulse && Address == CTRL_PORT) irqEnable <= Data[0];
      irq <= irqEnable & txIdle;
    end
  end
`else
  logic unusedCtrl;
  assign unusedCtrl = ^CTRL_PORT;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_io.sv
// Bench for uart_tx_fifo_io: queue-based line model checked every cycle, plus literal frame/status checks.
module tb_uart_tx_fifo_io;
  localparam int         CLK_HZ = 400;
  localparam int         BAUD   = 100;
  localparam int         DIV    = CLK_HZ / BAUD;
  localparam int         DEPTH  = 4;
  localparam logic [7:0] DPORT  = 8'h00;
  localparam logic [7:0] SPORT  = 8'h02;
  localparam logic [7:0] CPORT  = 8'h03;
`ifdef UART_TX_FIFO_IO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Address;
  wire  [7:0] Data;
  logic       IORQ, RD, WR;
  logic       uart_tx, irq;
  logic [7:0] dataDrv;
  logic       drvEn;

  assign Data = drvEn ? dataDrv : 8'bz;
  // Bus pull-ups: an undriven bus reads 0xFF
  for (genvar i = 0; i < 8; i++) begin : gPull
    pullup (Data[i]);
  end

  uart_tx_fifo_io #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
    .DATA_PORT(DPORT), .STATUS_PORT(SPORT), .CTRL_PORT(CPORT)
  ) dut (
    .clk(clk), .reset(reset), .Address(Address), .Data(Data),
    .IORQ(IORQ), .RD(RD), .WR(WR), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic txHist  [16384];
  logic irqHist [16384];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: queue of accepted bytes plus one frame in flight
  logic [7:0] q[$];
  logic [7:0] cur;
  logic       act, mOvf, mIrqEn, mIrq;
  int         pos, hiCnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      act = 0; pos = 0; hiCnt = 0; mOvf = 0; mIrqEn = 0; mIrq = 0; cur = 0;
    end else begin
      mIrq = mIrqEn && (q.size() == 0) && !act;
      if (act) begin
        pos++;
        if (pos == 10 * DIV) act = 0;
      end
      if (!act && q.size() > 0) begin
        cur = q.pop_front();
        act = 1;
        pos = 0;
      end
      if (IORQ && WR && !RD) hiCnt++; else hiCnt = 0;
      if (hiCnt == 3) begin
        if (Address == DPORT) begin
          if (q.size() < DEPTH) q.push_back(Data);
          else mOvf = 1;
        end else if (Address == SPORT) mOvf = 0;
        else if (IRQ_ON && Address == CPORT) mIrqEn = Data[0];
      end
    end
  end

  function automatic logic expTx();
    int b;
    if (!act) return 1'b1;
    b = pos / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  function automatic logic [7:0] expStatus();
    int n = q.size();
    logic [4:0] c = 5'(n > 31 ? 31 : n);
    return {c, mOvf, (n == 0 && !act), (n == DEPTH)};
  endfunction

  always @(negedge clk) begin
    #2;
    if (cyc < 16384) begin
      txHist[cyc]  = uart_tx;
      irqHist[cyc] = irq;
    end
    chk("uart_tx", {15'd0, uart_tx}, {15'd0, expTx()});
    chk("irq", {15'd0, irq}, {15'd0, mIrq});
    if (IORQ && RD && !WR && Address == SPORT) chk("status_bus", {8'd0, Data}, {8'd0, expStatus()});
    else if (!drvEn) chk("bus_released", {8'd0, Data}, 16'h00FF);
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hi, input int lo);
    Address = a; dataDrv = d; drvEn = 1; IORQ = 1; WR = 1;
    repeat (hi) @(negedge clk);
    IORQ = 0; WR = 0; drvEn = 0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rdAt(input logic [7:0] a, input logic io, output logic [7:0] v);
    Address = a; IORQ = io; RD = 1;
    #1 v = Data;
    @(negedge clk);
    IORQ = 0; RD = 0;
  endtask

  task automatic waitCyc(input int tgt);
    while (cyc < tgt) @(negedge clk);
  endtask

  logic [7:0] v;
  logic [9:0] fr;
  logic       allHigh;
  int         t0;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1; IORQ = 0; RD = 0; WR = 0; Address = 0; dataDrv = 0; drvEn = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    rdAt(SPORT, 1, v);
    chk("reset_status", {8'd0, v}, 16'h0002);
    chk("reset_tx", {15'd0, uart_tx}, 16'd1);

    // Single 0x55 frame from idle
    t0 = cyc;
    wr(DPORT, 8'h55, 3, 3);
    waitCyc(t0 + 45);
    rdAt(SPORT, 1, v);
    chk("status_after_frame", {8'd0, v}, 16'h0002);
    chk("tx_high_at_E2", {15'd0, txHist[t0+3]}, 16'd1);
    chk("tx_falls_at_E3", {15'd0, txHist[t0+4]}, 16'd0);
    for (int k = 0; k < 10; k++) fr[k] = txHist[t0 + 4 + k*DIV + 1];
    chk("frame_55", {6'd0, fr}, 16'h02AA);

    // Three back-to-back frames
    t0 = cyc;
    wr(DPORT, 8'h41, 3, 3);
    wr(DPORT, 8'h42, 3, 3);
    wr(DPORT, 8'h43, 3, 3);
    rdAt(SPORT, 1, v);
    chk("b2b_count_2", {11'd0, v[7:3]}, 16'd2);
    waitCyc(t0 + 46);
    rdAt(SPORT, 1, v);
    chk("b2b_count_1", {11'd0, v[7:3]}, 16'd1);
    waitCyc(t0 + 86);
    rdAt(SPORT, 1, v);
    chk("b2b_count_0", {11'd0, v[7:3]}, 16'd0);
    chk("b2b_stop_end", {15'd0, txHist[t0+43]}, 16'd1);
    chk("b2b_no_gap", {15'd0, txHist[t0+44]}, 16'd0);
    waitCyc(t0 + 130);

    // Overflow with a depth-4 FIFO
    t0 = cyc;
    for (int i = 0; i < 6; i++) wr(DPORT, 8'(8'h30 + i), 3, 3);
    rdAt(SPORT, 1, v);
    chk("overflow_status", {8'd0, v}, 16'h0025);
    wr(SPORT, 8'hFF, 3, 3);
    rdAt(SPORT, 1, v);
    chk("overflow_cleared", {8'd0, v}, 16'h0021);
    waitCyc(t0 + 260);

    // Reads that must leave the bus alone
    rdAt(8'h05, 1, v);
    chk("other_addr_z", {8'd0, v}, 16'h00FF);
    rdAt(SPORT, 0, v);
    chk("no_iorq_z", {8'd0, v}, 16'h00FF);

    // Reset in the middle of data bit 3
    t0 = cyc;
    wr(DPORT, 8'hF0, 3, 3);
    wr(DPORT, 8'h12, 3, 3);
    waitCyc(t0 + 21);
    chk("bit3_low", {15'd0, uart_tx}, 16'd0);
    #3 reset = 1;
    #1 chk("reset_tx_now", {15'd0, uart_tx}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    rdAt(SPORT, 1, v);
    chk("status_after_reset", {8'd0, v}, 16'h0002);
    t0 = cyc;
    waitCyc(t0 + 60);
    allHigh = 1;
    for (int k = t0; k < t0 + 60; k++) allHigh &= txHist[k];
    chk("no_residual_frame", {15'd0, allHigh}, 16'd1);

    // TX-idle interrupt
    wr(CPORT, 8'h01, 3, 3);
    t0 = cyc;
    wr(DPORT, 8'hA5, 3, 3);
    waitCyc(t0 + 50);
    chk("irq_idle", {15'd0, irqHist[t0+3]}, {15'd0, IRQ_ON});
    chk("irq_after_push", {15'd0, irqHist[t0+4]}, 16'd0);
    chk("irq_before_idle", {15'd0, irqHist[t0+44]}, 16'd0);
    chk("irq_after_stop", {15'd0, irqHist[t0+45]}, {15'd0, IRQ_ON});

    // Randomised traffic against the model
    for (int n = 0; n < 150; n++) begin
      int op = $urandom_range(0, 9);
      int hi = $urandom_range(3, 5);
      int lo = $urandom_range(1, 4);
      if (op <= 4)      wr(DPORT, 8'($urandom), hi, lo);
      else if (op == 5) wr(SPORT, 8'($urandom), hi, lo);
      else if (op == 6) wr(CPORT, 8'($urandom), hi, lo);
      else if (op == 7) wr(8'h07, 8'($urandom), hi, lo);
      else if (op == 8) rdAt(SPORT, 1, v);
      else              rdAt(8'($urandom_range(4, 255)), 1, v);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    waitCyc(cyc + (DEPTH + 2) * 10 * DIV);
    rdAt(SPORT, 1, v);
    chk("final_idle", {14'd0, v[1:0]}, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
